// File: rtl/act_stream_if.sv
// Stream bundle between the activation units and the collector: valid-only
// input side, valid/ready output side with frame marker.
interface act_stream_if #(
    parameter int DATA_W = 16
);
    logic              in_vld;
    logic [DATA_W-1:0] in_data;
    logic              out_vld;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport slave  (input  in_vld, in_data, out_ready,
                    output out_vld, out_data, out_last);
    modport master (output in_vld, in_data, out_ready,
                    input  out_vld, out_data, out_last);
endinterface

// File: rtl/act_stream_collector.sv
// Elastic FIFO behind the activation units: absorbs downstream stalls,
// flags dropped samples and marks frame boundaries on the output stream.
module act_stream_collector #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    act_stream_if.slave              s,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              frame_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [IW-1:0]     idx;
    logic              full, empty, wr_en, drop, xfer, at_last;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign wr_en   = s.in_vld && !full && !clr;
    assign drop    = s.in_vld && full && !clr;
    assign xfer    = !empty && s.out_ready && !clr;
    assign at_last = (idx == IW'(FRAME_LEN - 1));

    assign s.out_vld  = !empty;
    assign s.out_data = mem[rd_ptr];
    assign s.out_last = !empty && at_last;

    // Storage is reset so the head reads 0 out of reset; pointers wrap
    // naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= s.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            idx      <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (xfer)  rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !xfer)      level <= level + 1'b1;
            else if (xfer && !wr_en) level <= level - 1'b1;
            if (drop) overflow <= 1'b1;
            if (xfer) idx <= at_last ? '0 : idx + 1'b1;
        end
    end

    // Frame count survives clr: it tracks delivered frames, not FIFO state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  frame_cnt <= '0;
        else if (xfer && at_last) frame_cnt <= frame_cnt + 16'd1;
    end
endmodule
